// File: rtl/hwag_pkg.sv
// Shared definitions for the crank-wheel (HWAG) generator family.
package hwag_pkg;

  localparam int unsigned MIN_PER = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TOOTH = 2'd1,
    ST_GAP   = 2'd2
  } wheel_state_e;

endpackage

// File: rtl/counter_compare.sv
// Free-running up counter that wraps to zero when it reaches a programmable limit.
module counter_compare #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         hit_c
);

  assign hit_c = (count == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= hit_c ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vr_wheel_gen.sv
// Variable-reluctance crank wheel emulator: N-tooth wheel with a missing-tooth gap,
// programmable tooth period with a shadow register applied at position boundaries.
module vr_wheel_gen
  import hwag_pkg::*;
#(
  parameter int unsigned PW = 24,
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          per_ld,
  input  logic [PW-1:0] per_in,
  input  logic [TW-1:0] teeth_total,
  input  logic [1:0]    gap_teeth,
  output logic          vr_out,
  output logic [TW-1:0] tooth_idx,
  output logic          gap_strobe,
  output logic          busy
);

  wheel_state_e  state;
  logic [PW-1:0] shadow;
  logic [PW-1:0] per_act;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] p_eff_c;
  logic [PW-1:0] lim_c;
  logic [TW-1:0] nxt_idx_c;
  logic [TW-1:0] gap_lo_c;
  logic          pcnt_hit_c;
  logic          boundary_c;
  logic          cnt_clr_c;
  logic          run_ok_c;
  logic          gap_en_c;
  logic          nxt_gap_c;
  logic          vr_mid_c;

  // Position bookkeeping; wheel geometry is only consumed on boundaries and at start.
  always_comb begin
    p_eff_c    = (per_act < PW'(MIN_PER)) ? PW'(MIN_PER) : per_act;
    lim_c      = p_eff_c - PW'(1);
    boundary_c = pcnt_hit_c && (state != ST_IDLE);
    cnt_clr_c  = (state == ST_IDLE) || !ena;
    run_ok_c   = (teeth_total >= TW'(2));
    gap_en_c   = run_ok_c && (gap_teeth != 2'd0) &&
                 (TW'(gap_teeth) < (teeth_total - TW'(1)));
    gap_lo_c   = teeth_total - TW'(gap_teeth);
    nxt_idx_c  = (!run_ok_c || (tooth_idx >= (teeth_total - TW'(1)))) ? '0
                                                                       : tooth_idx + TW'(1);
    nxt_gap_c  = gap_en_c && (nxt_idx_c >= gap_lo_c);
    vr_mid_c   = (state == ST_TOOTH) && ((pcnt + PW'(1)) < (p_eff_c >> 1));
  end

  counter_compare #(
    .W(PW)
  ) u_pcnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (cnt_clr_c),
    .en    (state != ST_IDLE),
    .limit (lim_c),
    .count (pcnt),
    .hit_c (pcnt_hit_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
    end else if (per_ld) begin
      shadow <= per_in;
    end
  end

  // Wheel FSM; outputs are precomputed for the cycle being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      per_act    <= '0;
      tooth_idx  <= '0;
      vr_out     <= 1'b0;
      gap_strobe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          vr_out     <= 1'b0;
          tooth_idx  <= '0;
          gap_strobe <= 1'b0;
          busy       <= 1'b0;
          if (ena && run_ok_c) begin
            state   <= ST_TOOTH;
            per_act <= shadow;
            vr_out  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        default: begin
          if (!ena) begin
            state      <= ST_IDLE;
            vr_out     <= 1'b0;
            tooth_idx  <= '0;
            gap_strobe <= 1'b0;
            busy       <= 1'b0;
          end else if (boundary_c) begin
            per_act    <= shadow;
            tooth_idx  <= nxt_idx_c;
            state      <= nxt_gap_c ? ST_GAP : ST_TOOTH;
            vr_out     <= !nxt_gap_c;
            gap_strobe <= (state == ST_GAP) && (nxt_idx_c == '0);
          end else begin
            vr_out     <= vr_mid_c;
            gap_strobe <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vr_wheel_gen.sv
// Bench for vr_wheel_gen: expected tooth rises are queued at stimulus time and
// matched against the waveform as it appears.
module tb_vr_wheel_gen;

  localparam int unsigned PW = 24;
  localparam int unsigned TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          per_ld;
  logic [PW-1:0] per_in;
  logic [TW-1:0] teeth_total;
  logic [1:0]    gap_teeth;
  logic          vr_out;
  logic [TW-1:0] tooth_idx;
  logic          gap_strobe;
  logic          busy;

  vr_wheel_gen #(.PW(PW), .TW(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .per_ld      (per_ld),
    .per_in      (per_in),
    .teeth_total (teeth_total),
    .gap_teeth   (gap_teeth),
    .vr_out      (vr_out),
    .tooth_idx   (tooth_idx),
    .gap_strobe  (gap_strobe),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int idx;
    int strobe;
    int high;
  } ev_t;

  typedef struct {
    int per;
    int tt;
    int gap;
    int npos;
    int exp_rises;
  } vec_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  nrise = 0;
  int  rise_cyc = 0;
  int  exp_high = 0;
  bit  prev_vr = 1'b0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int eff(int p);
    return (p < 4) ? 4 : p;
  endfunction

  function automatic void push_one(int c, int idx, int strobe, int high);
    ev_t e;
    e.cyc = c; e.idx = idx; e.strobe = strobe; e.high = high;
    sb.push_back(e);
  endfunction

  // Expected teeth for positions m_lo..m_hi of a run started when ena rose at cycle base.
  function automatic void push_run(int base, int p, int tt, int g, int m_lo, int m_hi);
    for (int m = m_lo; m <= m_hi; m++) begin
      int idx;
      bit gap_en;
      idx    = m % tt;
      gap_en = (g != 0) && (g < tt - 1);
      if (!(gap_en && idx >= tt - g))
        push_one(base + 1 + m * p, idx, (gap_en && idx == 0 && m > 0) ? 1 : 0, p / 2);
    end
  endfunction

  // Waveform monitor, sampled mid-cycle.
  always @(negedge clk) begin
    ev_t e;
    if (vr_out && !prev_vr) begin
      nrise++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_rise: got rise at cycle %0d idx %0d want none", cyc, tooth_idx);
      end else begin
        e = sb.pop_front();
        chk("rise_cycle", cyc, e.cyc);
        chk("rise_idx", int'(tooth_idx), e.idx);
        chk("rise_strobe", int'(gap_strobe), e.strobe);
        exp_high = e.high;
        rise_cyc = cyc;
      end
    end else if (gap_strobe) begin
      chk("stray_strobe", 1, 0);
    end
    if (!vr_out && prev_vr) chk("high_len", cyc - rise_cyc, exp_high);
    prev_vr = vr_out;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic load_per(int p);
    per_in = PW'(p);
    per_ld = 1'b1;
    step(1);
    per_ld = 1'b0;
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_vr"}, int'(vr_out), 0);
    chk({tag, "_idx"}, int'(tooth_idx), 0);
    chk({tag, "_strobe"}, int'(gap_strobe), 0);
  endtask

  vec_t vecs[8];
  int   en;

  initial begin
    vecs[0] = '{100, 60, 2, 61, 59};
    vecs[1] = '{3,   10, 2, 21, 17};
    vecs[2] = '{0,    8, 1, 17, 15};
    vecs[3] = '{7,   12, 3, 25, 19};
    vecs[4] = '{5,   36, 0, 40, 40};
    vecs[5] = '{6,    4, 3, 12, 12};
    vecs[6] = '{6,    5, 3, 15,  6};
    vecs[7] = '{5,    2, 1,  8,  8};

    rst = 1'b0; ena = 1'b0; per_ld = 1'b0; per_in = '0;
    teeth_total = TW'(60); gap_teeth = 2'd2;
    step(3);
    chk_idle("reset");
    rst = 1'b1;
    step(2);

    // A wheel with fewer than two positions never leaves IDLE.
    load_per(5);
    teeth_total = TW'(1);
    nrise = 0;
    ena = 1'b1;
    step(10);
    chk("tiny_wheel_busy", int'(busy), 0);
    chk("tiny_wheel_rises", nrise, 0);
    ena = 1'b0;
    step(2);

    for (int i = 0; i < 8; i++) begin
      int pe;
      load_per(vecs[i].per);
      teeth_total = TW'(vecs[i].tt);
      gap_teeth   = 2'(vecs[i].gap);
      step(1);
      nrise = 0;
      pe = eff(vecs[i].per);
      ena = 1'b1;
      en = cyc;
      push_run(en, pe, vecs[i].tt, vecs[i].gap, 0, vecs[i].npos - 1);
      wait_until(en + vecs[i].npos * pe);
      ena = 1'b0;
      step(2);
      chk_idle("vec_stop");
      chk("vec_rises", nrise, vecs[i].exp_rises);
      chk("vec_drain", sb.size(), 0);
      sb.delete();
    end

    // Period change mid-tooth, then a load coinciding with a boundary.
    load_per(100);
    teeth_total = TW'(60); gap_teeth = 2'd2;
    step(1);
    nrise = 0;
    ena = 1'b1;
    en = cyc;
    for (int m = 0; m < 4; m++) push_one(en + 1 + m * 100, m, 0, 50);
    push_one(en + 401, 4, 0, 100);
    push_one(en + 601, 5, 0, 100);
    push_one(en + 801, 6, 0, 25);
    push_one(en + 851, 7, 0, 25);
    wait_until(en + 341);
    per_in = PW'(200); per_ld = 1'b1;
    step(1);
    per_ld = 1'b0;
    wait_until(en + 600);
    per_in = PW'(50); per_ld = 1'b1;
    step(1);
    per_ld = 1'b0;
    wait_until(en + 900);
    ena = 1'b0;
    step(2);
    chk("reload_rises", nrise, 8);
    chk("reload_drain", sb.size(), 0);
    sb.delete();

    // Drop enable at tooth 30, then restart from position 0 without a strobe.
    load_per(5);
    step(1);
    ena = 1'b1;
    en = cyc;
    push_run(en, 5, 60, 2, 0, 30);
    wait_until(en + 152);
    chk("stop_idx", int'(tooth_idx), 30);
    chk("stop_vr_before", int'(vr_out), 1);
    ena = 1'b0;
    step(1);
    chk_idle("ena_drop");
    step(3);
    ena = 1'b1;
    en = cyc;
    push_run(en, 5, 60, 2, 0, 4);
    wait_until(en + 25);
    ena = 1'b0;
    step(2);
    chk("restart_drain", sb.size(), 0);
    sb.delete();

    // Reset in the gap clears everything, including the shadow period.
    load_per(5);
    teeth_total = TW'(10); gap_teeth = 2'd2;
    step(1);
    ena = 1'b1;
    en = cyc;
    push_run(en, 5, 10, 2, 0, 7);
    wait_until(en + 45);
    chk("gap_busy", int'(busy), 1);
    #2;
    rst = 1'b0; ena = 1'b0;
    #1;
    chk_idle("rst_gap");
    @(posedge clk); #1;
    rst = 1'b1;
    step(2);
    chk("rst_no_autostart", int'(busy), 0);
    chk("rst_gap_drain", sb.size(), 0);
    sb.delete();
    ena = 1'b1;
    en = cyc;
    push_run(en, 4, 10, 2, 0, 4);
    push_one(en + 21, 5, 0, 1);
    wait_until(en + 22);
    chk("pre_rst_vr", int'(vr_out), 1);
    #2;
    rst = 1'b0; ena = 1'b0;
    #1;
    chk("rst_vr_async", int'(vr_out), 0);
    chk("rst_busy_async", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(2);
    chk("rst_tooth_drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
